// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: FSM states,
// iteration-counter width and the divide-by-zero quotient pattern.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    // One extra bit so the counter can hold WIDTH itself if ever needed.
    localparam int CNT_W = $clog2(DIV_WIDTH) + 1;

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_if.sv
// Operand/result handshake bundle between the execute stage (master)
// and the divider (slave).
interface div_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             div_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             cancel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, div_signed, dividend, divisor, cancel, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, div_signed, dividend, divisor, cancel, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift the partial remainder left,
// bring in the next dividend bit, trial-subtract the divisor and keep
// the difference only if it did not go negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   prem_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   prem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // Trial subtraction; the top bit of the difference is its sign.
    always_comb begin
        shifted  = {prem_in, next_bit};
        trial    = shifted - {2'b00, divisor};
        q_bit    = ~trial[WIDTH+1];
        prem_out = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Operands are reduced to magnitudes on accept, divided unsigned, and the
// captured signs are re-applied on the final iteration.
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic div_clk,
    input  logic reset,
    div_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   prem_q, prem_d;
    // Dividend magnitude shifts out of the top while quotient bits shift in at the bottom.
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             out_valid_q, out_valid_d;

    logic             in_ready_int;
    logic             accept;
    logic             dvd_neg;
    logic             dsr_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;
    logic [WIDTH:0]   step_prem;
    logic             step_qbit;
    logic [WIDTH-1:0] final_quot;
    logic [WIDTH-1:0] final_rem;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .prem_in (prem_q),
        .next_bit(dvd_q[WIDTH-1]),
        .divisor (dsr_q),
        .prem_out(step_prem),
        .q_bit   (step_qbit)
    );

    // Ready when idle, or when the held result is being taken this cycle.
    assign in_ready_int = !reset && !bus.cancel &&
                          ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready));
    assign accept       = bus.in_valid && in_ready_int;

    assign bus.in_ready    = in_ready_int;
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

    // Operand magnitudes and the unsigned result of the last iteration.
    always_comb begin
        dvd_neg    = bus.div_signed && bus.dividend[WIDTH-1];
        dsr_neg    = bus.div_signed && bus.divisor[WIDTH-1];
        dvd_mag    = dvd_neg ? ({WIDTH{1'b0}} - bus.dividend) : bus.dividend;
        dsr_mag    = dsr_neg ? ({WIDTH{1'b0}} - bus.divisor) : bus.divisor;
        final_quot = {dvd_q[WIDTH-2:0], step_qbit};
        final_rem  = step_prem[WIDTH-1:0];
    end

    // Next-state and datapath: iterate in CALC, hold in DONE, then apply
    // a new accept, and finally let cancel override everything but IDLE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prem_d      = prem_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
            end
            ST_CALC: begin
                prem_d = step_prem;
                dvd_d  = {dvd_q[WIDTH-2:0], step_qbit};
                if (cnt_q == LAST_ITER) begin
                    cnt_d       = '0;
                    quot_d      = q_neg_q ? ({WIDTH{1'b0}} - final_quot) : final_quot;
                    rem_d       = r_neg_q ? ({WIDTH{1'b0}} - final_rem) : final_rem;
                    dbz_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        if (accept) begin
            q_neg_d = dvd_neg ^ dsr_neg;
            r_neg_d = dvd_neg;
            prem_d  = '0;
            cnt_d   = '0;
            dvd_d   = dvd_mag;
            dsr_d   = dsr_mag;
            if (bus.divisor == '0) begin
                state_d     = ST_DONE;
                quot_d      = DBZ_QUOTIENT;
                rem_d       = bus.dividend;
                dbz_d       = 1'b1;
                out_valid_d = 1'b1;
            end else begin
                state_d     = ST_CALC;
                dbz_d       = 1'b0;
                out_valid_d = 1'b0;
            end
        end

        if (bus.cancel && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous clear.
    always_ff @(posedge div_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            prem_q      <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prem_q      <= prem_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
